// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: issues aligned imem reads for accepted PCs, matches in-order
// responses to their PCs and queues fetched instructions for decode; flush drops everything.
module ifetch_unit #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc_i,
    input  logic                   pc_valid_i,
    output logic                   pc_ready_o,
    input  logic                   flush_i,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]    instr_pc_o,
    output logic                   instr_misalign_o,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] kill_q, kill_d;
    logic [CW-1:0] qcount_q, qcount_d;
    logic [AW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic [AW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;

    logic [PC_WIDTH-1:0]    pend_mem_q [DEPTH];
    logic [INSTR_WIDTH-1:0] qi_mem_q   [DEPTH];
    logic [PC_WIDTH-1:0]    qp_mem_q   [DEPTH];
    logic                   qm_mem_q   [DEPTH];

    logic                credit;
    logic                hs;
    logic                q_push;
    logic                q_pop;
    logic [PC_WIDTH-1:0] rsp_pc;

    assign credit      = ({1'b0, inflight_q} + {1'b0, qcount_q}) < (CW+1)'(DEPTH);
    assign imem_req_o  = pc_valid_i & credit & ~flush_i & ~rst;
    assign imem_addr_o = {pc_i[PC_WIDTH-1:2], 2'b00};
    assign hs          = imem_req_o & imem_gnt_i;
    assign pc_ready_o  = hs;
    assign rsp_pc      = pend_mem_q[pend_rd_q];

    assign instr_valid_o    = (qcount_q != '0);
    assign instr_o          = instr_valid_o ? qi_mem_q[q_rd_q] : '0;
    assign instr_pc_o       = instr_valid_o ? qp_mem_q[q_rd_q] : '0;
    assign instr_misalign_o = instr_valid_o & qm_mem_q[q_rd_q];

    always_comb begin
        q_push     = imem_rvalid_i & ~flush_i & (kill_q == '0);
        q_pop      = instr_valid_o & instr_ready_i & ~flush_i;
        inflight_d = inflight_q + CW'(hs) - CW'(imem_rvalid_i);
        pend_wr_d  = hs ? pend_wr_q + AW'(1) : pend_wr_q;
        pend_rd_d  = imem_rvalid_i ? pend_rd_q + AW'(1) : pend_rd_q;
        kill_d     = kill_q;
        qcount_d   = qcount_q + CW'(q_push) - CW'(q_pop);
        q_wr_d     = q_push ? q_wr_q + AW'(1) : q_wr_q;
        q_rd_d     = q_pop ? q_rd_q + AW'(1) : q_rd_q;
        if (flush_i) begin
            // inflight already covers responses marked for killing, so everything still
            // outstanding after this cycle's response becomes a kill.
            kill_d   = inflight_q - CW'(imem_rvalid_i);
            qcount_d = '0;
            q_wr_d   = '0;
            q_rd_d   = '0;
        end else if (imem_rvalid_i && kill_q != '0) begin
            kill_d = kill_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            kill_q     <= '0;
            qcount_q   <= '0;
            pend_wr_q  <= '0;
            pend_rd_q  <= '0;
            q_wr_q     <= '0;
            q_rd_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            qcount_q   <= qcount_d;
            pend_wr_q  <= pend_wr_d;
            pend_rd_q  <= pend_rd_d;
            q_wr_q     <= q_wr_d;
            q_rd_q     <= q_rd_d;
        end
    end

    // Storage carries no reset: outputs are gated by the registered queue count.
    always_ff @(posedge clk) begin
        if (hs) begin
            pend_mem_q[pend_wr_q] <= pc_i;
        end
        if (q_push) begin
            qi_mem_q[q_wr_q] <= imem_rdata_i;
            qp_mem_q[q_wr_q] <= rsp_pc;
            qm_mem_q[q_wr_q] <= (rsp_pc[1:0] != 2'b00);
        end
    end

    a_rvalid_without_request : assert property (@(posedge clk) disable iff (rst)
        imem_rvalid_i |-> (inflight_q != '0));

    a_pending_overflow : assert property (@(posedge clk) disable iff (rst)
        hs |-> (inflight_q != CW'(DEPTH)) || imem_rvalid_i);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: handshake, credit back-pressure, flush/kill, misalignment
// and asynchronous reset, each checked against hand-computed values.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_misalign_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    int nvec = 0;
    int nerr = 0;

    ifetch_unit #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .pc_valid_i       (pc_valid_i),
        .pc_ready_o       (pc_ready_o),
        .flush_i          (flush_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_misalign_o (instr_misalign_o),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_valid_i    = 1'b0;
        flush_i       = 1'b0;
        imem_rvalid_i = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        pc_i          = 32'hBFC0_0000;
        pc_valid_i    = 1'b1;
        flush_i       = 1'b0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        step();
        chk("rst_req", imem_req_o, 0);
        chk("rst_ready", pc_ready_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", instr_pc_o, 0);
        chk("rst_mis", instr_misalign_o, 0);

        // 1: single fetch, response one cycle after grant
        rst = 1'b0;
        #1;
        chk("t1_req", imem_req_o, 1);
        chk("t1_addr", imem_addr_o, 32'hBFC0_0000);
        chk("t1_ready", pc_ready_o, 1);
        step();
        pc_valid_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0050_0093;
        #1;
        chk("t1_valid_early", instr_valid_o, 0);
        step();
        imem_rvalid_i = 1'b0;
        chk("t1_valid", instr_valid_o, 1);
        chk("t1_instr", instr_o, 32'h0050_0093);
        chk("t1_pc", instr_pc_o, 32'hBFC0_0000);
        chk("t1_mis", instr_misalign_o, 0);
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        chk("t1_popped", instr_valid_o, 0);

        // 2: back-pressure with decode stalled
        pc_i = 32'h100; pc_valid_i = 1'b1;
        #1;
        chk("t2_rdy100", pc_ready_o, 1);
        step();
        pc_i = 32'h104; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hAAAA_0100;
        #1;
        chk("t2_rdy104", pc_ready_o, 1);
        step();
        pc_i = 32'h108; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hAAAA_0104;
        #1;
        chk("t2_rdy108_blk", pc_ready_o, 0);
        step();
        imem_rvalid_i = 1'b0;
        chk("t2_rdy108_full", pc_ready_o, 0);
        chk("t2_head0_pc", instr_pc_o, 32'h100);
        chk("t2_head0", instr_o, 32'hAAAA_0100);
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        chk("t2_rdy108_ok", pc_ready_o, 1);
        chk("t2_head1_pc", instr_pc_o, 32'h104);
        chk("t2_head1", instr_o, 32'hAAAA_0104);
        step();
        pc_valid_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hAAAA_0108;
        instr_ready_i = 1'b1;
        step();
        imem_rvalid_i = 1'b0;
        chk("t2_head2_pc", instr_pc_o, 32'h108);
        step();
        instr_ready_i = 1'b0;
        chk("t2_drained", instr_valid_o, 0);

        // 3: flush with two requests outstanding
        instr_ready_i = 1'b1;
        pc_i = 32'h200; pc_valid_i = 1'b1;
        step();
        pc_i = 32'h204;
        #1;
        chk("t3_rdy204", pc_ready_o, 1);
        step();
        pc_i = 32'h208; flush_i = 1'b1;
        #1;
        chk("t3_req_in_flush", imem_req_o, 0);
        step();
        idle_inputs();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_0200;
        #1;
        chk("t3_flushed", instr_valid_o, 0);
        step();
        imem_rdata_i = 32'hDEAD_0204;
        #1;
        chk("t3_kill0", instr_valid_o, 0);
        step();
        imem_rvalid_i = 1'b0;
        chk("t3_kill1", instr_valid_o, 0);
        pc_i = 32'h300; pc_valid_i = 1'b1;
        #1;
        chk("t3_rdy300", pc_ready_o, 1);
        step();
        pc_valid_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_0300;
        step();
        imem_rvalid_i = 1'b0;
        chk("t3_valid300", instr_valid_o, 1);
        chk("t3_pc300", instr_pc_o, 32'h300);
        chk("t3_instr300", instr_o, 32'h1234_0300);
        step();
        chk("t3_drained", instr_valid_o, 0);

        // 4: response coincident with flush, one more in flight
        pc_i = 32'h500; pc_valid_i = 1'b1;
        step();
        pc_i = 32'h504;
        step();
        pc_valid_i = 1'b0; flush_i = 1'b1;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0500;
        step();
        flush_i = 1'b0; imem_rdata_i = 32'hBAD0_0504;
        #1;
        chk("t4_valid_a", instr_valid_o, 0);
        step();
        imem_rvalid_i = 1'b0;
        chk("t4_valid_b", instr_valid_o, 0);
        step();
        chk("t4_valid_c", instr_valid_o, 0);

        // 5: misaligned PC
        pc_i = 32'h402; pc_valid_i = 1'b1;
        #1;
        chk("t5_addr", imem_addr_o, 32'h400);
        step();
        pc_valid_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
        step();
        imem_rvalid_i = 1'b0;
        chk("t5_valid", instr_valid_o, 1);
        chk("t5_mis", instr_misalign_o, 1);
        chk("t5_pc", instr_pc_o, 32'h402);
        step();
        instr_ready_i = 1'b0;

        // 6: asynchronous reset with one queued entry and one in flight
        pc_i = 32'h600; pc_valid_i = 1'b1;
        step();
        pc_i = 32'h604; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0600;
        step();
        imem_rvalid_i = 1'b0;
        chk("t6_queued", instr_valid_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", instr_valid_o, 0);
        chk("t6_rst_req", imem_req_o, 0);
        chk("t6_rst_instr", instr_o, 0);
        step();
        rst = 1'b0;
        pc_i = 32'h700; pc_valid_i = 1'b1;
        #1;
        chk("t6_rdy700", pc_ready_o, 1);
        step();
        pc_valid_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0700;
        step();
        imem_rvalid_i = 1'b0;
        chk("t6_valid700", instr_valid_o, 1);
        chk("t6_pc700", instr_pc_o, 32'h700);
        chk("t6_instr700", instr_o, 32'h0000_0700);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
